// File: rtl/project_selector.sv
// Wishbone-controlled one-hot project enable with break-before-make guard interval.
// Optional sticky select lock when PROJ_SEL_LOCK_EN is defined.
module project_selector #(
  parameter int unsigned NUM_PROJECTS = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  output logic [NUM_PROJECTS-1:0] active,
  output logic                    busy
);

  typedef enum logic {StIdle, StGuard} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cur_q, cur_d;
  logic [7:0]              pending_q, pending_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    range_err_q, range_err_d;
  logic [NUM_PROJECTS-1:0] active_q, active_d;
  logic                    ack_q;
  logic [31:0]             dat_q, rdata;
  logic                    hit, wr, sel_wr, id_ok;
  logic [7:0]              wr_id;
  logic                    locked, lock_err, ctrl_rd;
  logic                    unused;

  // The ~ack_q term forces an idle cycle between consecutive acks.
  assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]) & ~ack_q;
  assign wr     = hit & wbs_we_i & wbs_sel_i[0];
  assign sel_wr = wr & (wbs_adr_i[3:2] == 2'd0);
  assign wr_id  = wbs_dat_i[7:0];
  assign id_ok  = 32'(wr_id) < NUM_PROJECTS;
  assign unused = ^{wbs_sel_i[3:1], wbs_dat_i[31:8], wbs_adr_i[1:0]};

`ifdef PROJ_SEL_LOCK_EN
  logic lock_q, lock_err_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lock_q     <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      if (wr && wbs_adr_i[3:2] == 2'd2 && wbs_dat_i[0]) lock_q <= 1'b1;
      if (sel_wr && lock_q) lock_err_q <= 1'b1;
    end
  end

  assign locked   = lock_q;
  assign lock_err = lock_err_q;
  assign ctrl_rd  = lock_q;
`else
  assign locked   = 1'b0;
  assign lock_err = 1'b0;
  assign ctrl_rd  = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pending_d   = pending_q;
    cnt_d       = cnt_q;
    range_err_d = range_err_q;
    active_d    = '0;

    if (sel_wr && !locked) begin
      if (!id_ok) begin
        range_err_d = 1'b1;
      end else begin
        range_err_d = 1'b0;
        pending_d   = wr_id;
        if (state_q == StIdle && wr_id != cur_q) begin
          state_d = StGuard;
          cnt_d   = 8'(GUARD_CYCLES - 1);
        end
      end
    end

    // A write landing on the final guard cycle still wins.
    if (state_q == StGuard) begin
      if (cnt_q == 8'd0) begin
        state_d = StIdle;
        cur_d   = pending_d;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    if (state_d == StIdle) begin
      for (int unsigned i = 1; i < NUM_PROJECTS; i++) begin
        active_d[i] = (cur_d == 8'(i));
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (wbs_adr_i[3:2])
      2'd0:    rdata[7:0] = busy ? pending_q : cur_q;
      2'd1:    rdata = {14'b0, lock_err, range_err_q, 7'b0, busy, cur_q};
      2'd2:    rdata[0] = ctrl_rd;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      cur_q       <= 8'd0;
      pending_q   <= 8'd0;
      cnt_q       <= 8'd0;
      range_err_q <= 1'b0;
      active_q    <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      range_err_q <= range_err_d;
      active_q    <= active_d;
      ack_q       <= hit;
      dat_q       <= (hit && !wbs_we_i) ? rdata : 32'd0;
    end
  end

  assign busy      = (state_q == StGuard);
  assign active    = active_q;
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_project_selector.sv
// Scoreboard bench for project_selector: read data is queued on issue and checked on ack.
module tb_project_selector;
  localparam int unsigned NP = 8;
  localparam int unsigned G  = 16;
  localparam logic [31:0] A_SEL  = 32'h3000_0000;
  localparam logic [31:0] A_STAT = 32'h3000_0004;
  localparam logic [31:0] A_CTRL = 32'h3000_0008;
  localparam logic [31:0] A_RSV  = 32'h3000_000C;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]    wbs_sel_i = 4'h0;
  logic [31:0]   wbs_adr_i = '0, wbs_dat_i = '0;
  logic          wbs_ack_o;
  logic [31:0]   wbs_dat_o;
  logic [NP-1:0] active;
  logic          busy;

  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  logic        watch_p2 = 1'b0;
  logic        busy_at_ack = 1'b0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  project_selector #(
    .NUM_PROJECTS(NP),
    .BASE_ADDR(32'h3000_0000),
    .GUARD_CYCLES(G)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .active   (active),
    .busy     (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      check("onehot", 32'($onehot0(active)), 32'd1);
      check("bit0_off", 32'(active[0]), 32'd0);
      if (watch_p2) check("never_p2", 32'(active[2]), 32'd0);
    end
  end

  // Entered and left on a negedge; k is the edge number at which the hit was sampled.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [3:0] sel, input bit expect_ack, output int k);
    bit got;
    got = 1'b0;
    k = -1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel;  wbs_adr_i = a;    wbs_dat_i = d;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        got = 1'b1;
        k = cyc_n;
        busy_at_ack = busy;
        if (!we) begin
          check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check(tag_q.pop_front(), wbs_dat_o, exp_q.pop_front());
        end
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_sel_i = 4'h0;
    check("ack_seen", 32'(got), 32'(expect_ack));
    if (!got && !we && expect_ack && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(tag_q.pop_front());
    end
    @(negedge wb_clk_i);
    check("ack_single", 32'(wbs_ack_o), 32'd0);
    check("dat_idle", wbs_dat_o, 32'd0);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, output int k);
    xfer(a, d, 1'b1, 4'hF, 1'b1, k);
  endtask

  task automatic wb_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int k;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    xfer(a, 32'd0, 1'b0, 4'hF, 1'b1, k);
  endtask

  task automatic wait_edge(input int e);
    while (cyc_n < e) @(negedge wb_clk_i);
  endtask

  task automatic watch_guard(input int k, input logic [NP-1:0] exp, input string tag);
    while (cyc_n < k + int'(G)) begin
      check({tag, "_guard_off"}, 32'(active), 32'd0);
      check({tag, "_guard_busy"}, 32'(busy), 32'd1);
      @(negedge wb_clk_i);
    end
    check({tag, "_cycle"}, cyc_n, k + int'(G));
    check({tag, "_active"}, 32'(active), 32'(exp));
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, k2, k4;

    repeat (2) @(negedge wb_clk_i);
    check("rst_active", 32'(active), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    wb_read(A_STAT, 32'h0000_0000, "rst_status");
    wb_read(A_SEL, 32'h0000_0000, "rst_select");

    // First switch: 0 -> 3.
    wb_write(A_SEL, 32'd3, k);
    check("sw3_busy_at_k", 32'(busy_at_ack), 32'd1);
    watch_guard(k, 8'b0000_1000, "sw3");
    wb_read(A_STAT, 32'h0000_0003, "sw3_status");

    // Retarget mid-guard: 3 -> 2, then 4 at k+5; counter must not restart.
    watch_p2 = 1'b1;
    wb_write(A_SEL, 32'd2, k2);
    wait_edge(k2 + 4);
    wb_write(A_SEL, 32'd4, k4);
    check("retarget_edge", k4, k2 + 5);
    wb_read(A_SEL, 32'd4, "select_pending");
    watch_guard(k2, 8'b0001_0000, "sw4");
    watch_p2 = 1'b0;

    // Out-of-range ID.
    wb_write(A_SEL, 32'd9, k);
    check("range_busy", 32'(busy), 32'd0);
    check("range_active", 32'(active), 32'h10);
    wb_read(A_STAT, 32'h0001_0004, "range_status");
    wb_write(A_SEL, 32'd1, k);
    watch_guard(k, 8'b0000_0010, "sw1");
    wb_read(A_STAT, 32'h0000_0001, "range_cleared");

    // Same ID and sel[0]=0 writes are no-ops.
    wb_write(A_SEL, 32'd1, k);
    check("same_busy", 32'(busy), 32'd0);
    xfer(A_SEL, 32'd5, 1'b1, 4'b1110, 1'b1, k);
    check("nosel_busy", 32'(busy), 32'd0);
    check("nosel_active", 32'(active), 32'h02);
    wb_read(A_SEL, 32'd1, "nosel_select");

    // Switch to 0 ends with everything off.
    wb_write(A_SEL, 32'd0, k);
    watch_guard(k, 8'b0000_0000, "sw0");
    wb_read(A_STAT, 32'h0000_0000, "sw0_status");

    // Reserved offset and address miss.
    wb_write(A_RSV, 32'hFFFF_FFFF, k);
    wb_read(A_RSV, 32'd0, "reserved_read");
    xfer(32'h3000_0010, 32'd0, 1'b0, 4'hF, 1'b0, k);

    // Asynchronous reset mid-guard.
    wb_write(A_SEL, 32'd6, k);
    wb_read(A_STAT, 32'h0000_0100, "guard_status");
    wb_read(A_SEL, 32'd6, "guard_select");
    #2 wb_rst_i = 1'b1;
    #1;
    check("arst_active", 32'(active), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    wb_read(A_STAT, 32'h0000_0000, "arst_status");
    wb_read(A_SEL, 32'h0000_0000, "arst_select");

    // Lock behaviour depends on the build.
    wb_write(A_CTRL, 32'd1, k);
`ifdef PROJ_SEL_LOCK_EN
    wb_read(A_CTRL, 32'd1, "ctrl_read");
    wb_write(A_SEL, 32'd2, k);
    check("lock_busy", 32'(busy), 32'd0);
    check("lock_active", 32'(active), 32'd0);
    wb_read(A_STAT, 32'h0002_0000, "lock_status");
`else
    wb_read(A_CTRL, 32'd0, "ctrl_read");
    wb_write(A_SEL, 32'd2, k);
    watch_guard(k, 8'b0000_0100, "nolock_sw2");
    wb_read(A_STAT, 32'h0000_0002, "nolock_status");
`endif

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
